// File: rtl/id_ex_stage_if.sv
// ID/EX pipeline-register bus: decoded ID fields in, registered EX fields out.
// The master side is the decode stage and the EX consumer; the slave side is id_ex_stage.
interface id_ex_stage_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  id_valid;
  logic                  id_reg_dst;
  logic                  id_reg_write;
  logic [1:0]            id_alu_op;
  logic                  id_alu_src;
  logic                  id_mem_w;
  logic                  id_mem_r;
  logic                  id_mem_to_reg;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic [REG_ADDR_W-1:0] id_rd;
  logic [DATA_W-1:0]     id_rs_data;
  logic [DATA_W-1:0]     id_rt_data;
  logic [DATA_W-1:0]     id_imm;
  logic [5:0]            id_funct;
  logic                  flush;
  logic                  ex_hold;

  logic                  stall;
  logic                  ex_valid;
  logic                  ex_reg_write;
  logic                  ex_alu_src;
  logic                  ex_mem_w;
  logic                  ex_mem_r;
  logic                  ex_mem_to_reg;
  logic [1:0]            ex_alu_op;
  logic [DATA_W-1:0]     ex_rs_data;
  logic [DATA_W-1:0]     ex_rt_data;
  logic [DATA_W-1:0]     ex_imm;
  logic [5:0]            ex_funct;
  logic [REG_ADDR_W-1:0] ex_rs;
  logic [REG_ADDR_W-1:0] ex_rt;
  logic [REG_ADDR_W-1:0] ex_wr_addr;

  modport master (
    output id_valid, id_reg_dst, id_reg_write, id_alu_op, id_alu_src, id_mem_w, id_mem_r,
           id_mem_to_reg, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm, id_funct,
           flush, ex_hold,
    input  stall, ex_valid, ex_reg_write, ex_alu_src, ex_mem_w, ex_mem_r, ex_mem_to_reg,
           ex_alu_op, ex_rs_data, ex_rt_data, ex_imm, ex_funct, ex_rs, ex_rt, ex_wr_addr
  );

  modport slave (
    input  id_valid, id_reg_dst, id_reg_write, id_alu_op, id_alu_src, id_mem_w, id_mem_r,
           id_mem_to_reg, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm, id_funct,
           flush, ex_hold,
    output stall, ex_valid, ex_reg_write, ex_alu_src, ex_mem_w, ex_mem_r, ex_mem_to_reg,
           ex_alu_op, ex_rs_data, ex_rt_data, ex_imm, ex_funct, ex_rs, ex_rt, ex_wr_addr
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion, flush and hold.
// Optional macro ID_EX_STALL_CNT_EN adds a saturating 16-bit load-use stall counter output.
module id_ex_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  id_ex_stage_if.slave bus
`ifdef ID_EX_STALL_CNT_EN
  ,
  output logic [15:0]  stall_cnt
`endif
);

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  alu_src;
    logic                  mem_w;
    logic                  mem_r;
    logic                  mem_to_reg;
    logic [1:0]            alu_op;
    logic [DATA_W-1:0]     rs_data;
    logic [DATA_W-1:0]     rt_data;
    logic [DATA_W-1:0]     imm;
    logic [5:0]            funct;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] wr_addr;
  } ex_t;

  ex_t  ex_q;
  ex_t  ex_d;
  ex_t  captured;
  logic rt_used;
  logic hazard;

  // A load in EX blocks any ID instruction that reads its destination; rt only counts as a
  // source for R-type (reg_dst) and store (mem_w) encodings.
  always_comb begin
    rt_used = bus.id_reg_dst | bus.id_mem_w;
    hazard  = ex_q.valid & ex_q.mem_r & (ex_q.wr_addr != '0) & bus.id_valid &
              ((ex_q.wr_addr == bus.id_rs) | (rt_used & (ex_q.wr_addr == bus.id_rt)));
  end

  assign bus.stall = rst_n & (hazard | bus.ex_hold);

  always_comb begin
    captured            = '0;
    captured.valid      = bus.id_valid;
    captured.reg_write  = bus.id_reg_write & bus.id_valid;
    captured.alu_src    = bus.id_alu_src & bus.id_valid;
    captured.mem_w      = bus.id_mem_w & bus.id_valid;
    captured.mem_r      = bus.id_mem_r & bus.id_valid;
    captured.mem_to_reg = bus.id_mem_to_reg & bus.id_valid;
    captured.alu_op     = bus.id_valid ? bus.id_alu_op : 2'b00;
    captured.rs_data    = bus.id_rs_data;
    captured.rt_data    = bus.id_rt_data;
    captured.imm        = bus.id_imm;
    captured.funct      = bus.id_funct;
    captured.rs         = bus.id_rs;
    captured.rt         = bus.id_rt;
    captured.wr_addr    = bus.id_reg_dst ? bus.id_rd : bus.id_rt;

    ex_d = ex_q;
    if (bus.flush) begin
      ex_d = '0;
    end else if (bus.ex_hold) begin
      ex_d = ex_q;
    end else if (hazard) begin
      ex_d = '0;
    end else begin
      ex_d = captured;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

`ifdef ID_EX_STALL_CNT_EN
  // Counts load-use stall edges, including those spent under ex_hold; a flush cancels that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (hazard && !bus.flush && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_reg_write  = ex_q.reg_write;
  assign bus.ex_alu_src    = ex_q.alu_src;
  assign bus.ex_mem_w      = ex_q.mem_w;
  assign bus.ex_mem_r      = ex_q.mem_r;
  assign bus.ex_mem_to_reg = ex_q.mem_to_reg;
  assign bus.ex_alu_op     = ex_q.alu_op;
  assign bus.ex_rs_data    = ex_q.rs_data;
  assign bus.ex_rt_data    = ex_q.rt_data;
  assign bus.ex_imm        = ex_q.imm;
  assign bus.ex_funct      = ex_q.funct;
  assign bus.ex_rs         = ex_q.rs;
  assign bus.ex_rt         = ex_q.rt;
  assign bus.ex_wr_addr    = ex_q.wr_addr;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, hand-written corner sequences,
// and randomized traffic against a rule-level model of the ID/EX register.
`timescale 1ns/1ps
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage_if bus();

`ifdef ID_EX_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  id_ex_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus)
`ifdef ID_EX_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  typedef struct packed {
    logic        valid;
    logic        reg_dst;
    logic        reg_write;
    logic [1:0]  alu_op;
    logic        alu_src;
    logic        mem_w;
    logic        mem_r;
    logic        mem_to_reg;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [5:0]  funct;
    logic        flush;
    logic        hold;
  } id_t;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        alu_src;
    logic        mem_w;
    logic        mem_r;
    logic        mem_to_reg;
    logic [1:0]  alu_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wr_addr;
  } ex_t;

  typedef struct {
    id_t        in;
    logic       stall;
    logic [10:0] ex_sum;
  } vec_t;

  localparam int NV = 20;
  vec_t vec [NV];

  int compared   = 0;
  int mismatched = 0;

  ex_t         m;
  int unsigned m_cnt;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input id_t t);
    bus.id_valid      = t.valid;
    bus.id_reg_dst    = t.reg_dst;
    bus.id_reg_write  = t.reg_write;
    bus.id_alu_op     = t.alu_op;
    bus.id_alu_src    = t.alu_src;
    bus.id_mem_w      = t.mem_w;
    bus.id_mem_r      = t.mem_r;
    bus.id_mem_to_reg = t.mem_to_reg;
    bus.id_rs         = t.rs;
    bus.id_rt         = t.rt;
    bus.id_rd         = t.rd;
    bus.id_rs_data    = t.rs_data;
    bus.id_rt_data    = t.rt_data;
    bus.id_imm        = t.imm;
    bus.id_funct      = t.funct;
    bus.flush         = t.flush;
    bus.ex_hold       = t.hold;
  endtask

  function automatic ex_t readEx();
    ex_t e;
    e.valid      = bus.ex_valid;
    e.reg_write  = bus.ex_reg_write;
    e.alu_src    = bus.ex_alu_src;
    e.mem_w      = bus.ex_mem_w;
    e.mem_r      = bus.ex_mem_r;
    e.mem_to_reg = bus.ex_mem_to_reg;
    e.alu_op     = bus.ex_alu_op;
    e.rs_data    = bus.ex_rs_data;
    e.rt_data    = bus.ex_rt_data;
    e.imm        = bus.ex_imm;
    e.funct      = bus.ex_funct;
    e.rs         = bus.ex_rs;
    e.rt         = bus.ex_rt;
    e.wr_addr    = bus.ex_wr_addr;
    return e;
  endfunction

  function automatic logic [10:0] exSummary(input ex_t e);
    return {e.valid, e.reg_write, e.mem_r, e.mem_w, e.alu_op, e.wr_addr};
  endfunction

  function automatic id_t instr(input logic valid, input logic reg_dst, input logic reg_write,
                                input logic [1:0] alu_op, input logic alu_src, input logic mem_w,
                                input logic mem_r, input logic mem_to_reg,
                                input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    id_t t;
    t.valid      = valid;
    t.reg_dst    = reg_dst;
    t.reg_write  = reg_write;
    t.alu_op     = alu_op;
    t.alu_src    = alu_src;
    t.mem_w      = mem_w;
    t.mem_r      = mem_r;
    t.mem_to_reg = mem_to_reg;
    t.rs         = rs;
    t.rt         = rt;
    t.rd         = rd;
    t.rs_data    = 32'hA000_0000 | {27'd0, rs};
    t.rt_data    = 32'hB000_0000 | {27'd0, rt};
    t.imm        = 32'hFFFF_FF00 | {27'd0, rd};
    t.funct      = 6'h20 | {1'b0, rd};
    t.flush      = 1'b0;
    t.hold       = 1'b0;
    return t;
  endfunction

  function automatic id_t r_type(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return instr(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, rs, rt, rd);
  endfunction

  function automatic id_t lw(input logic [4:0] rs, input logic [4:0] rt);
    return instr(1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, rs, rt, 5'd0);
  endfunction

  function automatic id_t sw(input logic [4:0] rs, input logic [4:0] rt);
    return instr(1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, rs, rt, 5'd0);
  endfunction

  function automatic id_t imm_op(input logic [1:0] op, input logic [4:0] rs, input logic [4:0] rt);
    return instr(1'b1, 1'b0, 1'b1, op, 1'b1, 1'b0, 1'b0, 1'b0, rs, rt, 5'd0);
  endfunction

  function automatic vec_t row(input id_t in, input logic flush, input logic hold, input logic stall,
                               input logic valid, input logic rw, input logic mem_r, input logic mem_w,
                               input logic [1:0] alu_op, input logic [4:0] wr);
    vec_t v;
    v.in       = in;
    v.in.flush = flush;
    v.in.hold  = hold;
    v.stall    = stall;
    v.ex_sum   = {valid, rw, mem_r, mem_w, alu_op, wr};
    return v;
  endfunction

  // Reference model: a load sitting in EX with a nonzero destination blocks any valid ID
  // instruction that reads that register.
  function automatic logic modelHazard(input ex_t e, input id_t t);
    logic load_in_ex;
    logic reads_dest;
    load_in_ex = e.valid && e.mem_r && (e.wr_addr != 5'd0);
    reads_dest = (t.rs == e.wr_addr) || ((t.reg_dst || t.mem_w) && (t.rt == e.wr_addr));
    return t.valid && load_in_ex && reads_dest;
  endfunction

  function automatic ex_t modelNext(input ex_t e, input id_t t);
    ex_t n;
    if (t.flush) return '0;
    if (t.hold) return e;
    if (modelHazard(e, t)) return '0;
    n.valid      = t.valid;
    n.reg_write  = t.valid && t.reg_write;
    n.alu_src    = t.valid && t.alu_src;
    n.mem_w      = t.valid && t.mem_w;
    n.mem_r      = t.valid && t.mem_r;
    n.mem_to_reg = t.valid && t.mem_to_reg;
    n.alu_op     = t.valid ? t.alu_op : 2'b00;
    n.rs_data    = t.rs_data;
    n.rt_data    = t.rt_data;
    n.imm        = t.imm;
    n.funct      = t.funct;
    n.rs         = t.rs;
    n.rt         = t.rt;
    n.wr_addr    = t.reg_dst ? t.rd : t.rt;
    return n;
  endfunction

  task automatic resetDut();
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(instr(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Applies one ID slot, checks stall before the edge and the EX summary after it.
  task automatic stepCheck(input string name, input id_t t, input logic exp_stall,
                           input logic [10:0] exp_sum);
    @(negedge clk);
    applyStimulus(t);
    #1;
    checkOutput({name, " stall"}, 128'(bus.stall), 128'(exp_stall));
    @(posedge clk);
    #1;
    checkOutput({name, " ex"}, 128'(exSummary(readEx())), 128'(exp_sum));
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    id_t t;
    logic exp_stall;

    vec[0]  = row(r_type(5'd1, 5'd2, 5'd3),  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 5'd3);
    vec[1]  = row(lw(5'd1, 5'd5),            1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 5'd5);
    vec[2]  = row(r_type(5'd5, 5'd6, 5'd8),  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0);
    vec[3]  = row(r_type(5'd5, 5'd6, 5'd8),  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 5'd8);
    vec[4]  = row(lw(5'd1, 5'd0),            1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 5'd0);
    vec[5]  = row(r_type(5'd0, 5'd0, 5'd9),  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 5'd9);
    vec[6]  = row(lw(5'd1, 5'd5),            1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 5'd5);
    vec[7]  = row(imm_op(2'b11, 5'd1, 5'd5), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 5'd5);
    vec[8]  = row(lw(5'd2, 5'd7),            1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 5'd7);
    vec[9]  = row(sw(5'd2, 5'd7),            1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0);
    vec[10] = row(sw(5'd2, 5'd7),            1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 5'd7);
    vec[11] = row(imm_op(2'b01, 5'd3, 5'd4), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 5'd4);
    vec[12] = row(r_type(5'd1, 5'd2, 5'd10), 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 5'd4);
    vec[13] = row(r_type(5'd1, 5'd2, 5'd10), 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 5'd4);
    vec[14] = row(r_type(5'd1, 5'd2, 5'd10), 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 5'd4);
    vec[15] = row(r_type(5'd1, 5'd2, 5'd10), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0);
    vec[16] = row(instr(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd11),
                                             1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd11);
    vec[17] = row(lw(5'd1, 5'd12),           1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 5'd12);
    vec[18] = row(r_type(5'd12, 5'd1, 5'd13),1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0);
    vec[19] = row(r_type(5'd12, 5'd1, 5'd13),1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 5'd13);

    // Reset with arbitrary inputs, including a held stage.
    t = lw(5'd3, 5'd3);
    t.hold = 1'b1;
    applyStimulus(t);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset ex", 128'(readEx()), 128'(0));
    checkOutput("reset stall", 128'(bus.stall), 128'(0));
`ifdef ID_EX_STALL_CNT_EN
    checkOutput("reset stall_cnt", 128'(stall_cnt), 128'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      stepCheck($sformatf("row%0d", i), vec[i].in, vec[i].stall, vec[i].ex_sum);
    end
`ifdef ID_EX_STALL_CNT_EN
    checkOutput("table stall_cnt", 128'(stall_cnt), 128'(2));
`endif

    // Hazard under hold: the load stays in EX and stall stays high until the bubble goes in.
    resetDut();
    stepCheck("hh load", lw(5'd1, 5'd6), 1'b0, {1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 5'd6});
    t = r_type(5'd6, 5'd2, 5'd3);
    t.hold = 1'b1;
    stepCheck("hh hold1", t, 1'b1, {1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 5'd6});
    stepCheck("hh hold2", t, 1'b1, {1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 5'd6});
    t.hold = 1'b0;
    stepCheck("hh bubble", t, 1'b1, 11'd0);
    stepCheck("hh capture", t, 1'b0, {1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 5'd3});
`ifdef ID_EX_STALL_CNT_EN
    checkOutput("hh stall_cnt", 128'(stall_cnt), 128'(3));
`endif

    // Reset asserted mid-stall clears EX and drops stall without waiting for a clock.
    stepCheck("rm load", lw(5'd1, 5'd5), 1'b0, {1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 5'd5});
    @(negedge clk);
    applyStimulus(r_type(5'd5, 5'd1, 5'd2));
    #1;
    checkOutput("rm stall before reset", 128'(bus.stall), 128'(1));
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rm ex after reset", 128'(readEx()), 128'(0));
    checkOutput("rm stall after reset", 128'(bus.stall), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic with a small register pool so load-use collisions are frequent.
    resetDut();
    m = '0;
    m_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      t.valid      = ($urandom_range(0, 9) != 0);
      t.reg_dst    = 1'($urandom);
      t.reg_write  = 1'($urandom);
      t.alu_op     = 2'($urandom);
      t.alu_src    = 1'($urandom);
      t.mem_w      = ($urandom_range(0, 3) == 0);
      t.mem_r      = ($urandom_range(0, 1) == 0);
      t.mem_to_reg = 1'($urandom);
      t.rs         = 5'($urandom_range(0, 3));
      t.rt         = 5'($urandom_range(0, 3));
      t.rd         = 5'($urandom_range(0, 3));
      t.rs_data    = $urandom;
      t.rt_data    = $urandom;
      t.imm        = $urandom;
      t.funct      = 6'($urandom);
      t.flush      = ($urandom_range(0, 15) == 0);
      t.hold       = ($urandom_range(0, 7) == 0);
      applyStimulus(t);
      #1;
      exp_stall = modelHazard(m, t) || t.hold;
      checkOutput($sformatf("rand%0d stall", i), 128'(bus.stall), 128'(exp_stall));
      @(posedge clk);
      if (modelHazard(m, t) && !t.flush && m_cnt < 32'hFFFF) m_cnt++;
      m = modelNext(m, t);
      #1;
      checkOutput($sformatf("rand%0d ex", i), 128'(readEx()), 128'(m));
    end
`ifdef ID_EX_STALL_CNT_EN
    checkOutput("rand stall_cnt", 128'(stall_cnt), 128'(m_cnt));

    // Pin a hazard under hold long enough to run the counter past its ceiling.
    resetDut();
    stepCheck("sat load", lw(5'd1, 5'd6), 1'b0, {1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 5'd6});
    t = r_type(5'd6, 5'd2, 5'd3);
    t.hold = 1'b1;
    @(negedge clk);
    applyStimulus(t);
    repeat (65540) @(posedge clk);
    #1;
    checkOutput("sat stall_cnt", 128'(stall_cnt), 128'(16'hFFFF));
    checkOutput("sat ex", 128'(exSummary(readEx())), 128'({1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 5'd6}));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
